// File: rtl/slink_mmtx_if.sv
// Bundles the board-logic write port and the MACTX read port of the TX frame buffer.
//   wr_data/wr_en/wr_sop/wr_eop : one 16-bit frame word per wr_en cycle
//   mactx_mmtx_rdreq            : MACTX word request
//   mmtx_mactx_data/dval        : {sop,eop,payload}, valid one cycle after an accepted request
// master: board logic + MACTX side; slave: the frame buffer.
interface slink_mmtx_if;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_sop;
  logic        wr_eop;
  logic        mactx_mmtx_rdreq;
  logic [17:0] mmtx_mactx_data;
  logic        mmtx_mactx_dval;

  modport master (
    output wr_data, wr_en, wr_sop, wr_eop, mactx_mmtx_rdreq,
    input  mmtx_mactx_data, mmtx_mactx_dval
  );

  modport slave (
    input  wr_data, wr_en, wr_sop, wr_eop, mactx_mmtx_rdreq,
    output mmtx_mactx_data, mmtx_mactx_dval
  );
endinterface

// File: rtl/slink_mmtx.sv
// Store-and-forward TX frame buffer in front of the serial link MAC transmitter.
// Frames are written word by word and become readable only once their eop word is stored;
// overflowing, oversize and truncated frames are discarded and counted.
// Ports:
//   clk_12_5m    link-side clock
//   rst_12_5m_n  asynchronous active-low reset
//   bus          write port + MACTX read port (slink_mmtx_if.slave)
//   frame_rdy    at least one committed, unread word
//   frame_cnt    committed frames not yet fully read (saturating)
//   drop_cnt     dropped frames (saturating)
//   buf_full     buffer holds 2**AW words
module slink_mmtx #(
  parameter int unsigned AW        = 9,
  parameter int unsigned MAX_FRAME = 256
) (
  input  logic        clk_12_5m,
  input  logic        rst_12_5m_n,
  slink_mmtx_if.slave bus,
  output logic        frame_rdy,
  output logic [7:0]  frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        buf_full
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(MAX_FRAME + 1);
  localparam logic [PW-1:0] DepthVal = PW'(2 ** AW);
  localparam logic [PW-1:0] PtrOne   = PW'(1);
  localparam logic [LW-1:0] MaxLen   = LW'(MAX_FRAME);
  localparam logic [LW-1:0] LenOne   = LW'(1);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} wr_state_e;

  logic [17:0] mem_q [2 ** AW];

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] start_ptr_q, start_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic [17:0]   data_q, data_d;
  logic          dval_q, dval_d;
  logic          frame_rdy_q, frame_rdy_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          buf_full_q, buf_full_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [17:0]   mem_wdata;
  logic [17:0]   rd_word;
  logic [PW-1:0] base_ptr;
  logic [PW-1:0] base_used;
  logic          full_pre;
  logic          commit;
  logic          drop_inc;
  logic          rd_fire;
  logic          eop_out;

  assign mem_wdata = {bus.wr_sop, bus.wr_eop, bus.wr_data};
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];
  // Occupancy on pre-cycle pointers: a same-cycle read never frees room for this cycle's write.
  assign full_pre  = (wr_ptr_q - rd_ptr_q) == DepthVal;
  assign rd_fire   = bus.mactx_mmtx_rdreq && (rd_ptr_q != commit_ptr_q);
  assign eop_out   = dval_q && data_q[16];

  // Write side: frame assembly, commit and drop decisions.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    start_ptr_d  = start_ptr_q;
    len_d        = len_q;
    base_ptr     = wr_ptr_q;
    base_used    = '0;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q[AW-1:0];
    commit       = 1'b0;
    drop_inc     = 1'b0;
    if (bus.wr_en) begin
      if (bus.wr_sop) begin
        // A sop inside an open frame means the previous eop went missing: discard that frame
        // and restart from its start address in the same cycle.
        if (state_q == StFrame) begin
          base_ptr = start_ptr_q;
          drop_inc = 1'b1;
        end
        wr_ptr_d  = base_ptr;
        base_used = base_ptr - rd_ptr_q;
        if (base_used == DepthVal) begin
          drop_inc = 1'b1;
          state_d  = bus.wr_eop ? StIdle : StDrop;
        end else begin
          mem_we      = 1'b1;
          mem_waddr   = base_ptr[AW-1:0];
          start_ptr_d = base_ptr;
          wr_ptr_d    = base_ptr + PtrOne;
          len_d       = LenOne;
          if (bus.wr_eop) begin
            commit_ptr_d = base_ptr + PtrOne;
            commit       = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d = StFrame;
          end
        end
      end else if (state_q == StFrame) begin
        if (full_pre || (len_q == MaxLen)) begin
          wr_ptr_d = start_ptr_q;
          drop_inc = 1'b1;
          state_d  = StDrop;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          len_d    = len_q + LenOne;
          if (bus.wr_eop) begin
            commit_ptr_d = wr_ptr_q + PtrOne;
            commit       = 1'b1;
            state_d      = StIdle;
          end
        end
      end else if ((state_q == StDrop) && bus.wr_eop) begin
        state_d = StIdle;
      end
    end
  end

  // Read side and status counters.
  always_comb begin
    rd_ptr_d = rd_fire ? rd_ptr_q + PtrOne : rd_ptr_q;
    data_d   = rd_fire ? rd_word : data_q;
    dval_d   = rd_fire;

    frame_cnt_d = frame_cnt_q;
    if (commit && !eop_out && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (!commit && eop_out && (frame_cnt_q != 8'h00)) begin
      frame_cnt_d = frame_cnt_q - 8'd1;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    frame_rdy_d = rd_ptr_d != commit_ptr_d;
    buf_full_d  = (wr_ptr_d - rd_ptr_d) == DepthVal;
  end

  always_ff @(posedge clk_12_5m or negedge rst_12_5m_n) begin
    if (!rst_12_5m_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      start_ptr_q  <= '0;
      len_q        <= '0;
      data_q       <= '0;
      dval_q       <= 1'b0;
      frame_rdy_q  <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      buf_full_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      start_ptr_q  <= start_ptr_d;
      len_q        <= len_d;
      data_q       <= data_d;
      dval_q       <= dval_d;
      frame_rdy_q  <= frame_rdy_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      buf_full_q   <= buf_full_d;
    end
  end

  // Buffer RAM has no reset; contents are meaningless until written.
  always_ff @(posedge clk_12_5m) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.mmtx_mactx_data = data_q;
  assign bus.mmtx_mactx_dval = dval_q;
  assign frame_rdy           = frame_rdy_q;
  assign frame_cnt           = frame_cnt_q;
  assign drop_cnt            = drop_cnt_q;
  assign buf_full            = buf_full_q;

endmodule

// File: tb/tb_slink_mmtx.sv
// Bench for slink_mmtx: instance 0 uses the default geometry, instance 1 uses AW=4 to reach
// buffer-full quickly. A queue-level model predicts every output each cycle; literal checks pin
// the model against hand-computed values.
module tb_slink_mmtx;

  localparam int MaxF = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en  [2];
  logic        sop [2];
  logic        eop [2];
  logic        rq  [2];
  logic [15:0] wd  [2];

  logic        rdy_w  [2];
  logic [7:0]  fcnt_w [2];
  logic [15:0] dcnt_w [2];
  logic        full_w [2];
  logic        dv_w   [2];
  logic [17:0] dt_w   [2];

  int vectors     = 0;
  int miscompares = 0;

  slink_mmtx_if if0 ();
  slink_mmtx_if if1 ();

  assign if0.wr_data          = wd[0];
  assign if0.wr_en            = en[0];
  assign if0.wr_sop           = sop[0];
  assign if0.wr_eop           = eop[0];
  assign if0.mactx_mmtx_rdreq = rq[0];
  assign if1.wr_data          = wd[1];
  assign if1.wr_en            = en[1];
  assign if1.wr_sop           = sop[1];
  assign if1.wr_eop           = eop[1];
  assign if1.mactx_mmtx_rdreq = rq[1];
  assign dv_w[0] = if0.mmtx_mactx_dval;
  assign dt_w[0] = if0.mmtx_mactx_data;
  assign dv_w[1] = if1.mmtx_mactx_dval;
  assign dt_w[1] = if1.mmtx_mactx_data;

  slink_mmtx #(.AW(9), .MAX_FRAME(MaxF)) u_dut0 (
    .clk_12_5m   (clk),
    .rst_12_5m_n (rst_n),
    .bus         (if0),
    .frame_rdy   (rdy_w[0]),
    .frame_cnt   (fcnt_w[0]),
    .drop_cnt    (dcnt_w[0]),
    .buf_full    (full_w[0])
  );

  slink_mmtx #(.AW(4), .MAX_FRAME(MaxF)) u_dut1 (
    .clk_12_5m   (clk),
    .rst_12_5m_n (rst_n),
    .bus         (if1),
    .frame_rdy   (rdy_w[1]),
    .frame_cnt   (fcnt_w[1]),
    .drop_cnt    (dcnt_w[1]),
    .buf_full    (full_w[1])
  );

  // ---------------- behavioural model: committed FIFO + pending frame ----------------
  logic [17:0] cq [2][512];
  int          cq_head [2];
  int          cq_cnt  [2];
  logic [17:0] pq [2][512];
  int          pq_cnt  [2];
  int          mode    [2];  // 0 idle, 1 inside frame, 2 discarding
  int          m_drop  [2];
  int          m_fcnt  [2];
  logic        m_dval  [2];
  logic [17:0] m_data  [2];
  logic        m_rdy   [2];
  logic        m_full  [2];

  function automatic int depth(int k);
    return (k == 0) ? 512 : 16;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cq_head[k] = 0; cq_cnt[k] = 0; pq_cnt[k] = 0; mode[k] = 0;
      m_drop[k] = 0; m_fcnt[k] = 0; m_dval[k] = 1'b0; m_data[k] = '0;
      m_rdy[k] = 1'b0; m_full[k] = 1'b0;
    end
  endtask

  task automatic bump_drop(int k);
    if (m_drop[k] < 65535) m_drop[k]++;
  endtask

  task automatic model_step(int k);
    int d, cq_pre;
    bit full, dec, commit;
    d      = depth(k);
    cq_pre = cq_cnt[k];
    full   = (cq_cnt[k] + pq_cnt[k]) == d;
    dec    = m_dval[k] && m_data[k][16];
    commit = 1'b0;
    m_dval[k] = 1'b0;
    if (rq[k] && cq_cnt[k] > 0) begin
      m_data[k]  = cq[k][cq_head[k]];
      cq_head[k] = (cq_head[k] + 1) % 512;
      cq_cnt[k]--;
      m_dval[k]  = 1'b1;
    end
    if (en[k]) begin
      if (sop[k]) begin
        if (mode[k] == 1) begin
          pq_cnt[k] = 0;
          bump_drop(k);
        end
        if (cq_pre + pq_cnt[k] == d) begin
          bump_drop(k);
          mode[k] = eop[k] ? 0 : 2;
        end else begin
          pq[k][0]  = {1'b1, eop[k], wd[k]};
          pq_cnt[k] = 1;
          commit    = eop[k];
          mode[k]   = eop[k] ? 0 : 1;
        end
      end else if (mode[k] == 1) begin
        if (full || pq_cnt[k] == MaxF) begin
          pq_cnt[k] = 0;
          bump_drop(k);
          mode[k] = 2;
        end else begin
          pq[k][pq_cnt[k]] = {1'b0, eop[k], wd[k]};
          pq_cnt[k]++;
          commit = eop[k];
          if (eop[k]) mode[k] = 0;
        end
      end else if (mode[k] == 2 && eop[k]) begin
        mode[k] = 0;
      end
    end
    if (commit) begin
      for (int j = 0; j < pq_cnt[k]; j++) begin
        cq[k][(cq_head[k] + cq_cnt[k]) % 512] = pq[k][j];
        cq_cnt[k]++;
      end
      pq_cnt[k] = 0;
    end
    if (commit && !dec) begin
      if (m_fcnt[k] < 255) m_fcnt[k]++;
    end else if (dec && !commit && m_fcnt[k] > 0) begin
      m_fcnt[k]--;
    end
    m_rdy[k]  = cq_cnt[k] > 0;
    m_full[k] = (cq_cnt[k] + pq_cnt[k]) == d;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h, want %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk("dval",      k, 32'(dv_w[k]),   32'(m_dval[k]));
      chk("data",      k, 32'(dt_w[k]),   32'(m_data[k]));
      chk("frame_rdy", k, 32'(rdy_w[k]),  32'(m_rdy[k]));
      chk("frame_cnt", k, 32'(fcnt_w[k]), 32'(m_fcnt[k]));
      chk("drop_cnt",  k, 32'(dcnt_w[k]), 32'(m_drop[k]));
      chk("buf_full",  k, 32'(full_w[k]), 32'(m_full[k]));
    end
  endtask

  // One clock of stimulus on instance k; the other instance idles. Returns 1 time unit after
  // the edge that consumed the inputs, so outputs are settled for literal checks.
  task automatic cyc(int k, logic e, logic s, logic p, logic [15:0] d, logic r);
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; sop[i] = 1'b0; eop[i] = 1'b0; wd[i] = '0; rq[i] = 1'b0;
    end
    en[k] = e; sop[k] = s; eop[k] = p; wd[k] = d; rq[k] = r;
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int k, logic s, logic p, logic [15:0] d);
    cyc(k, 1'b1, s, p, d, 1'b0);
  endtask

  task automatic rd(int k);
    cyc(k, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic idle();
    cyc(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; sop[i] = 1'b0; eop[i] = 1'b0; wd[i] = '0; rq[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then requests on an empty buffer.
    chk("rst_frame_rdy", 0, 32'(rdy_w[0]), 32'd0);
    chk("rst_frame_cnt", 0, 32'(fcnt_w[0]), 32'd0);
    chk("rst_drop_cnt",  0, 32'(dcnt_w[0]), 32'd0);
    chk("rst_dval",      0, 32'(dv_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd(0);
      chk("empty_dval", 0, 32'(dv_w[0]), 32'd0);
    end

    // 4-word frame, read back-to-back.
    wr(0, 1'b1, 1'b0, 16'h1111);
    wr(0, 1'b0, 1'b0, 16'h2222);
    wr(0, 1'b0, 1'b0, 16'h3333);
    chk("pre_eop_frame_rdy", 0, 32'(rdy_w[0]), 32'd0);
    wr(0, 1'b0, 1'b1, 16'h4444);
    chk("commit_frame_rdy", 0, 32'(rdy_w[0]), 32'd1);
    chk("commit_frame_cnt", 0, 32'(fcnt_w[0]), 32'd1);
    rd(0); chk("w1", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h21111});
    rd(0); chk("w2", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h02222});
    rd(0); chk("w3", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h03333});
    rd(0); chk("w4", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h14444});
    idle();
    chk("drained_frame_cnt", 0, 32'(fcnt_w[0]), 32'd0);
    chk("drained_frame_rdy", 0, 32'(rdy_w[0]), 32'd0);

    // Truncated frame (no eop) followed by a good 2-word frame.
    wr(0, 1'b1, 1'b0, 16'hA001);
    wr(0, 1'b0, 1'b0, 16'hA002);
    wr(0, 1'b0, 1'b0, 16'hA003);
    wr(0, 1'b1, 1'b0, 16'hB001);
    chk("trunc_drop_cnt", 0, 32'(dcnt_w[0]), 32'd1);
    wr(0, 1'b0, 1'b1, 16'hB002);
    rd(0); chk("trunc_b1", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h2B001});
    rd(0); chk("trunc_b2", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h1B002});
    rd(0); chk("trunc_none", 0, 32'(dv_w[0]), 32'd0);

    // Oversize: MAX_FRAME+1 words without eop, then a 1-word frame.
    for (int i = 0; i <= MaxF; i++) begin
      wr(0, (i == 0), 1'b0, 16'hC000 + 16'(i));
    end
    chk("oversize_drop_cnt",  0, 32'(dcnt_w[0]), 32'd2);
    chk("oversize_frame_rdy", 0, 32'(rdy_w[0]), 32'd0);
    wr(0, 1'b1, 1'b1, 16'hD00D);
    chk("single_frame_cnt", 0, 32'(fcnt_w[0]), 32'd1);
    rd(0); chk("single_word", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h3D00D});
    idle();

    // Small buffer: 14-word frame A, then frame B overflows at its third word.
    for (int i = 0; i < 14; i++) begin
      wr(1, (i == 0), (i == 13), 16'hA000 + 16'(i));
    end
    chk("a_frame_cnt", 1, 32'(fcnt_w[1]), 32'd1);
    wr(1, 1'b1, 1'b0, 16'hB100);
    wr(1, 1'b0, 1'b0, 16'hB101);
    chk("b_full", 1, 32'(full_w[1]), 32'd1);
    wr(1, 1'b0, 1'b0, 16'hB102);
    chk("b_drop_cnt", 1, 32'(dcnt_w[1]), 32'd1);
    chk("b_not_full", 1, 32'(full_w[1]), 32'd0);
    wr(1, 1'b0, 1'b0, 16'hB103);
    wr(1, 1'b0, 1'b1, 16'hB104);
    chk("b_frame_cnt", 1, 32'(fcnt_w[1]), 32'd1);
    for (int i = 0; i < 14; i++) begin
      rd(1);
      chk("a_word", 1, {13'd0, dv_w[1], dt_w[1]},
          {13'd0, 1'b1, (i == 0), (i == 13), 16'hA000 + 16'(i)});
    end
    idle();
    chk("a_drained", 1, 32'(fcnt_w[1]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wr(1, (i == 0), (i == 4), 16'hE000 + 16'(i));
    end
    chk("e_frame_rdy", 1, 32'(rdy_w[1]), 32'd1);
    chk("e_frame_cnt", 1, 32'(fcnt_w[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd(1);
      chk("e_word", 1, {13'd0, dv_w[1], dt_w[1]},
          {13'd0, 1'b1, (i == 0), (i == 4), 16'hE000 + 16'(i)});
    end
    idle();

    // Reset mid-frame with two committed frames and a word on the output.
    wr(0, 1'b1, 1'b1, 16'hF001);
    wr(0, 1'b1, 1'b1, 16'hF002);
    wr(0, 1'b1, 1'b0, 16'hF003);
    chk("pre_rst_frame_cnt", 0, 32'(fcnt_w[0]), 32'd2);
    rd(0);
    chk("pre_rst_word", 0, {13'd0, dv_w[0], dt_w[0]}, {13'd0, 1'b1, 18'h3F001});
    rst_n = 1'b0;
    #1;
    chk("rst_dval_now",      0, 32'(dv_w[0]), 32'd0);
    chk("rst_data_now",      0, 32'(dt_w[0]), 32'd0);
    chk("rst_frame_cnt_now", 0, 32'(fcnt_w[0]), 32'd0);
    chk("rst_frame_rdy_now", 0, 32'(rdy_w[0]), 32'd0);
    chk("rst_drop_cnt_now",  0, 32'(dcnt_w[0]), 32'd0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    rd(0);
    chk("post_rst_dval", 0, 32'(dv_w[0]), 32'd0);
    chk("post_rst_rdy",  0, 32'(rdy_w[0]), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
